txn_wbuf: RTL and testbench

- Posted-write transaction buffer between fabric32's txn_* master port and the memory-side req/rdy slave.
- Presents an identical req/wr/addr/wdata/rdata/rdy interface on both sides, so it drops into the existing path with no change to either side.
- Writes are queued and retired in order, so the fabric does not stall on memory latency.
- Reads are queued behind all older writes, which preserves read-after-write ordering, and block the upstream port until their data returns.

---
 rtl/txn_if.sv | 20 ++
 rtl/txn_wbuf.sv | 145 ++++++++++++++
 tb/tb_txn_wbuf.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/txn_if.sv
// Request/response bus shared by fabric32's txn_* port and the memory side.
// The master drives the request fields; the slave answers with rdy and rdata.
interface txn_if;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdy;

  modport master (
    output req, wr, addr, wdata,
    input  rdata, rdy
  );

  modport slave (
    input  req, wr, addr, wdata,
    output rdata, rdy
  );
endinterface

// File: rtl/txn_wbuf.sv
// Posted-write transaction buffer: queues writes in order, holds the upstream
// port during reads so read-after-write ordering is preserved.
module txn_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  txn_if.slave        up,
  txn_if.master       mem,
  output logic [AW:0] level,
  output logic        idle,
  output logic        err_drop
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  // Entry layout: {wr, addr[31:0], wdata[31:0]}
  logic [64:0]   fifo_mem [DEPTH];
  logic [64:0]   head;

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          read_pending_reg;
  logic          err_drop_reg;

  state_t        state_reg;
  logic          mem_req_reg;
  logic          mem_wr_reg;
  logic [31:0]   mem_addr_reg;
  logic [31:0]   mem_wdata_reg;
  logic [31:0]   up_rdata_reg;

  logic          up_rdy;
  logic          push;
  logic          pop;
  logic          drop;

  assign up_rdy = (level_reg != FULL_LEVEL) && !read_pending_reg;
  assign push   = up.req && up_rdy;
  assign drop   = up.req && !up_rdy;
  assign pop    = (state_reg == S_IDLE) && (level_reg != '0) && mem.rdy;
  assign head   = fifo_mem[rd_ptr_reg];

  // Storage carries no reset; pointers and level define which entries are live.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == AW'(gi))) begin
          fifo_mem[gi] <= {up.wr, up.addr, up.wdata};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      err_drop_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (drop) begin
        err_drop_reg <= 1'b1;
      end
    end
  end

  // A read can only be accepted while nothing is pending, so the set and the
  // completion-clear below never coincide.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg        <= S_IDLE;
      mem_req_reg      <= 1'b0;
      mem_wr_reg       <= 1'b0;
      mem_addr_reg     <= '0;
      mem_wdata_reg    <= '0;
      up_rdata_reg     <= '0;
      read_pending_reg <= 1'b0;
    end else begin
      if (push && !up.wr) begin
        read_pending_reg <= 1'b1;
      end
      case (state_reg)
        S_IDLE: begin
          if (pop) begin
            mem_wr_reg    <= head[64];
            mem_addr_reg  <= head[63:32];
            mem_wdata_reg <= head[31:0];
            mem_req_reg   <= 1'b1;
            state_reg     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_req_reg <= 1'b0;
          state_reg   <= S_WAIT;
        end
        S_WAIT: begin
          if (mem.rdy) begin
            state_reg <= S_IDLE;
            if (!mem_wr_reg) begin
              up_rdata_reg     <= mem.rdata;
              read_pending_reg <= 1'b0;
            end
          end
        end
        default: begin
          mem_req_reg <= 1'b0;
          state_reg   <= S_IDLE;
        end
      endcase
    end
  end

  assign up.rdy    = up_rdy;
  assign up.rdata  = up_rdata_reg;
  assign mem.req   = mem_req_reg;
  assign mem.wr    = mem_wr_reg;
  assign mem.addr  = mem_addr_reg;
  assign mem.wdata = mem_wdata_reg;

  assign level    = level_reg;
  assign err_drop = err_drop_reg;
  assign idle     = (level_reg == '0) && (state_reg == S_IDLE) && !read_pending_reg;

endmodule

// File: tb/tb_txn_wbuf.sv
// Scoreboard bench for txn_wbuf: issued requests queue expected memory ops and
// read data; monitors on the memory and upstream sides pop and compare.
module tb_txn_wbuf;

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic [2:0] level;
  logic       idle;
  logic       err_drop;

  always #5 clk = ~clk;

  txn_if up_if ();
  txn_if mem_if ();

  txn_wbuf #(.DEPTH(4), .AW(2)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .up       (up_if),
    .mem      (mem_if),
    .level    (level),
    .idle     (idle),
    .err_drop (err_drop)
  );

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          mem_op_cnt = 0;
  logic        stall = 1'b0;
  logic [64:0] exp_q [$];
  logic [31:0] rd_q [$];

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one request at a negedge; only requests that will be accepted
  // are placed on the scoreboard.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input bit wait_rdy);
    int t;
    @(negedge clk);
    if (wait_rdy) begin
      t = 0;
      while (!up_if.rdy && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!up_if.rdy) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL up_rdy_timeout: got 0, expected 1");
      end
    end
    up_if.req   = 1'b1;
    up_if.wr    = wr;
    up_if.addr  = a;
    up_if.wdata = d;
    if (up_if.rdy) exp_q.push_back({wr, a, d});
    @(posedge clk);
    #1;
    up_if.req = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (!(idle && exp_q.size() == 0) && t < 500) begin
      step(1);
      t++;
    end
    chk(name, {63'd0, idle, (exp_q.size() == 0)}, 65'd3);
  endtask

  // Memory model and memory-side monitor: one wait state per op.
  initial begin
    logic pend;
    logic busy;
    pend = 1'b0;
    busy = 1'b0;
    mem_if.rdy   = 1'b1;
    mem_if.rdata = 32'h0;
    forever begin
      @(negedge clk);
      busy = pend;
      pend = 1'b0;
      if (mem_if.req === 1'b1) begin
        mem_op_cnt++;
        pend = 1'b1;
        if (exp_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL mem_op_unexpected: got %h, expected none",
                   {mem_if.wr, mem_if.addr, mem_if.wdata});
        end else begin
          chk("mem_op", {mem_if.wr, mem_if.addr, mem_if.wdata}, exp_q.pop_front());
        end
        if (!mem_if.wr)
          mem_if.rdata = (mem_if.addr == 32'h4000_0004) ? 32'h1234_5678 : ~mem_if.addr;
      end
      mem_if.rdy = !(stall || busy);
    end
  end

  // Upstream read-data monitor: compare when up_rdy returns after a read.
  initial begin
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (up_if.rdy && !prev && rd_q.size() > 0)
        chk("up_rdata", {33'd0, up_if.rdata}, {33'd0, rd_q.pop_front()});
      prev = up_if.rdy;
    end
  end

  initial begin
    int t;
    int ops_at_reset;
    up_if.req   = 1'b0;
    up_if.wr    = 1'b0;
    up_if.addr  = 32'h0;
    up_if.wdata = 32'h0;

    // Reset takes effect before any clock edge
    #2 arst_n = 1'b0;
    #1;
    chk("rst_async_level", level, 0);
    chk("rst_async_up_rdy", up_if.rdy, 1);
    #19 arst_n = 1'b1;
    step(3);
    chk("rst_up_rdy", up_if.rdy, 1);
    chk("rst_idle", idle, 1);
    chk("rst_level", level, 0);
    chk("rst_mem_req", mem_if.req, 0);
    chk("rst_err_drop", err_drop, 0);

    // Single write: latency and pulse width
    issue(1'b1, 32'h4000_2000, 32'hDEAD_BEEF, 1'b1);
    chk("w1_e0_up_rdy", up_if.rdy, 1);
    chk("w1_e0_mem_req", mem_if.req, 0);
    chk("w1_e0_level", level, 1);
    step(1);
    chk("w1_e1_mem_req", mem_if.req, 1);
    chk("w1_e1_mem_wr", mem_if.wr, 1);
    chk("w1_e1_mem_addr", mem_if.addr, 32'h4000_2000);
    chk("w1_e1_mem_wdata", mem_if.wdata, 32'hDEAD_BEEF);
    step(1);
    chk("w1_e2_mem_req", mem_if.req, 0);
    step(1);
    chk("w1_e3_idle", idle, 0);
    step(1);
    chk("w1_e4_idle", idle, 1);

    // Fill to DEPTH with memory busy, then overflow
    stall = 1'b1;
    step(2);
    for (int i = 0; i < 4; i++)
      issue(1'b1, 32'h4000_2000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
    chk("full_level", level, 4);
    chk("full_up_rdy", up_if.rdy, 0);
    issue(1'b1, 32'h4000_2010, 32'hBAD0_0000, 1'b0);
    chk("drop_err_drop", err_drop, 1);
    chk("drop_level", level, 4);
    stall = 1'b0;
    wait_drain("full_drain");
    chk("err_drop_sticky", err_drop, 1);

    // Read queued behind two writes
    issue(1'b1, 32'h4000_0000, 32'h1111_1111, 1'b1);
    issue(1'b1, 32'h4000_0008, 32'h2222_2222, 1'b1);
    issue(1'b0, 32'h4000_0004, 32'h0, 1'b1);
    rd_q.push_back(32'h1234_5678);
    chk("rd_up_rdy_low", up_if.rdy, 0);
    step(4);
    chk("rd_still_blocked", up_if.rdy, 0);
    wait_drain("rd_drain");
    chk("rd_up_rdata_hold", up_if.rdata, 32'h1234_5678);

    // Push and pop at the same edge with level 2, then continuous traffic
    stall = 1'b1;
    step(2);
    issue(1'b1, 32'h4000_3000, 32'hC000_0000, 1'b0);
    issue(1'b1, 32'h4000_3004, 32'hC000_0001, 1'b0);
    chk("pp_pre_level", level, 2);
    stall = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (mem_if.rdy !== 1'b1 && t < 50);
    up_if.req   = 1'b1;
    up_if.wr    = 1'b1;
    up_if.addr  = 32'h4000_3008;
    up_if.wdata = 32'hC000_0002;
    if (up_if.rdy) exp_q.push_back({1'b1, 32'h4000_3008, 32'hC000_0002});
    @(posedge clk);
    #1;
    up_if.req = 1'b0;
    chk("pp_level", level, 2);
    chk("pp_mem_req", mem_if.req, 1);
    for (int i = 3; i < 9; i++)
      issue(1'b1, 32'h4000_3000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b1);
    wait_drain("pp_drain");

    // Reset during WAIT with three entries still queued
    stall = 1'b1;
    step(2);
    for (int i = 0; i < 4; i++)
      issue(1'b1, 32'h4000_4000 + 32'(4 * i), 32'hE000_0000 + 32'(i), 1'b0);
    stall = 1'b0;
    t = 0;
    while (mem_if.req !== 1'b1 && t < 50) begin
      step(1);
      t++;
    end
    step(1);
    chk("mid_level", level, 3);
    arst_n = 1'b0;
    #1;
    chk("arst_mem_req", mem_if.req, 0);
    chk("arst_level", level, 0);
    chk("arst_mem_addr", mem_if.addr, 0);
    chk("arst_err_drop", err_drop, 0);
    exp_q.delete();
    rd_q.delete();
    step(2);
    arst_n = 1'b1;
    step(1);
    ops_at_reset = mem_op_cnt;
    step(20);
    chk("post_rst_up_rdy", up_if.rdy, 1);
    chk("post_rst_idle", idle, 1);
    chk("post_rst_no_ops", mem_op_cnt, ops_at_reset);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
